// File: rtl/sram_arbiter.sv
// Two-port arbiter and cycle sequencer for an external 8-bit asynchronous SRAM.
// Serialises core (port 0) and secondary-master (port 1) accesses into SETUP/ACCESS/HOLD phases.
module sram_arbiter #(
    parameter int AW           = 21,
    parameter int RD_WAIT      = 2,
    parameter int WR_WAIT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          sysclk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [7:0]    p0_wdata,
    output logic          p0_ack,
    output logic [7:0]    p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [7:0]    p1_wdata,
    output logic          p1_ack,
    output logic [7:0]    p1_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_dout,
    output logic          sram_doe,
    input  logic [7:0]    sram_din,
    output logic          sram_we_n,
    output logic          busy,
    output logic          owner
);

    localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic          doe_q, doe_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata0_q, rdata0_d;
    logic [7:0]    rdata1_q, rdata1_d;

    logic any_req, grant1, last_access;

    // Port 1 wins when alone, or when port 0 has used up its consecutive-grant allowance.
    assign any_req     = p0_req | p1_req;
    assign grant1      = p1_req & (~p0_req | (starve_q == SW'(STARVE_LIMIT)));
    assign last_access = (wait_q == (we_q ? CW'(WR_WAIT - 1) : CW'(RD_WAIT - 1)));

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            starve_q <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            doe_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            doe_q    <= doe_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (last_access) state_d = S_HOLD;
            S_HOLD:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wait_d   = wait_q;
        starve_d = starve_q;
        owner_d  = owner_q;
        we_d     = we_q;
        doe_d    = doe_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                // A port-0 grant while port 1 waits is the only case that counts toward starvation.
                if (!p1_req || grant1)
                    starve_d = '0;
                else if (starve_q != SW'(STARVE_LIMIT))
                    starve_d = starve_q + 1'b1;
                if (any_req) begin
                    owner_d = grant1;
                    we_d    = grant1 ? p1_we    : p0_we;
                    addr_d  = grant1 ? p1_addr  : p0_addr;
                    wdata_d = grant1 ? p1_wdata : p0_wdata;
                    doe_d   = grant1 ? p1_we    : p0_we;
                end
            end
            S_ACCESS: begin
                wait_d = wait_q + 1'b1;
                if (last_access && !we_q) begin
                    if (owner_q) rdata1_d = sram_din;
                    else         rdata0_d = sram_din;
                end
            end
            S_HOLD:  doe_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        sram_we_n = ~((state_q == S_ACCESS) & we_q);
        busy      = (state_q != S_IDLE);
        p0_ack    = (state_q == S_HOLD) & ~owner_q;
        p1_ack    = (state_q == S_HOLD) & owner_q;
    end

    assign sram_addr = addr_q;
    assign sram_dout = wdata_q;
    assign sram_doe  = doe_q;
    assign owner     = owner_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model, directed scenarios, random traffic.
module tb_sram_arbiter;

    localparam int AW  = 21;
    localparam int RDW = 2;
    localparam int WRW = 2;
    localparam int SL  = 4;

    logic          sysclk = 1'b0;
    logic          reset_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [7:0]    p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack;
    logic [7:0]    p0_rdata, p1_rdata;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dout, sram_din;
    logic          sram_doe, sram_we_n, busy, owner;

    always #5 sysclk = ~sysclk;

    sram_arbiter #(.AW(AW), .RD_WAIT(RDW), .WR_WAIT(WRW), .STARVE_LIMIT(SL)) dut (
        .sysclk(sysclk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
        .sram_din(sram_din), .sram_we_n(sram_we_n), .busy(busy), .owner(owner)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wd;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    logic [7:0] smem [logic [AW-1:0]];
    logic [7:0] mmem [logic [AW-1:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wel_cnt = 0;
    int age0 = 0;
    int age1 = 0;
    bit rnd_en = 1'b0;
    int ack_cyc[$];
    bit ack_port[$];

    // Reference model: one transaction at a time, tracked by its cycle offset since the grant.
    bit            m_busy, m_owner, m_we, m_doe;
    int            m_k, m_wait, m_starve;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wd, m_rd0, m_rd1;

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] sread(input logic [AW-1:0] a);
        return smem.exists(a) ? smem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] mread(input logic [AW-1:0] a);
        return mmem.exists(a) ? mmem[a] : init_byte(a);
    endfunction

    function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wd = d;
        return t;
    endfunction

    function automatic int ack_at(input int i);
        return (ack_cyc.size() > i) ? ack_cyc[i] : -1;
    endfunction

    function automatic int port_at(input int i);
        return (ack_port.size() > i) ? int'(ack_port[i]) : -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_we = 0; m_doe = 0;
        m_k = 0; m_wait = 0; m_starve = 0;
        m_addr = '0; m_wd = '0; m_rd0 = '0; m_rd1 = '0;
    endtask

    task automatic model_step();
        bit g1;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            g1 = p1_req && (!p0_req || m_starve == SL);
            if (p0_req && p1_req && m_starve < SL) m_starve++;
            else m_starve = 0;
            if (p0_req || p1_req) begin
                m_busy  = 1;
                m_k     = 1;
                m_owner = g1;
                m_we    = g1 ? p1_we : p0_we;
                m_addr  = g1 ? p1_addr : p0_addr;
                m_wd    = g1 ? p1_wdata : p0_wdata;
                m_doe   = m_we;
                m_wait  = m_we ? WRW : RDW;
            end
        end else begin
            if (m_k == m_wait + 1) begin
                if (m_we) mmem[m_addr] = m_wd;
                else if (m_owner) m_rd1 = mread(m_addr);
                else m_rd0 = mread(m_addr);
            end
            if (m_k == m_wait + 2) begin
                m_busy = 0;
                m_doe  = 0;
            end
            m_k++;
        end
    endtask

    task automatic compare_outputs();
        bit e_wen;
        e_wen = !(m_busy && m_we && m_k >= 2 && m_k <= m_wait + 1);
        chk("busy", busy, m_busy);
        chk("owner", owner, m_owner);
        chk("sram_we_n", sram_we_n, e_wen);
        chk("sram_doe", sram_doe, m_doe);
        chk("sram_addr", sram_addr, m_addr);
        chk("sram_dout", sram_dout, m_wd);
        chk("p0_ack", p0_ack, m_busy && m_k == m_wait + 2 && !m_owner);
        chk("p1_ack", p1_ack, m_busy && m_k == m_wait + 2 && m_owner);
        chk("p0_rdata", p0_rdata, m_rd0);
        chk("p1_rdata", p1_rdata, m_rd1);
    endtask

    function automatic txn_t rand_txn();
        logic [AW-1:0] a;
        a = AW'($urandom_range(15));
        if ($urandom_range(1) == 1) a = a ^ 21'h150A0;
        return mk(1'($urandom_range(1)), a, 8'($urandom));
    endfunction

    task automatic drive_cycle();
        bit a0, a1;
        @(negedge sysclk);
        cyc++;
        if (!sram_we_n) smem[sram_addr] = sram_dout;
        sram_din = sread(sram_addr);
        compare_outputs();
        a0 = p0_ack;
        a1 = p1_ack;
        if (a0) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b0); end
        if (a1) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b1); end
        if (!sram_we_n) wel_cnt++;
        if (p0_req) age0++;
        if (p1_req) age1++;
        @(posedge sysclk);
        model_step();
        #1;
        if (a0 && p0_req && q0.size() > 0) begin
            chk("p0_wait_bound", age0 <= 5 * (SL + 2) + 2, 1);
            void'(q0.pop_front());
            age0 = 0;
        end
        if (a1 && p1_req && q1.size() > 0) begin
            chk("p1_wait_bound", age1 <= 5 * (SL + 2) + 2, 1);
            void'(q1.pop_front());
            age1 = 0;
        end
        if (rnd_en && q0.size() == 0 && $urandom_range(3) == 0) q0.push_back(rand_txn());
        if (rnd_en && q1.size() == 0 && $urandom_range(3) == 0) q1.push_back(rand_txn());
        if (q0.size() > 0) begin
            p0_req = 1; p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wd;
        end else p0_req = 0;
        if (q1.size() > 0) begin
            p1_req = 1; p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wd;
        end else p1_req = 0;
    endtask

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < maxc) begin
            drive_cycle();
            n++;
        end
        chk("drain_timeout", q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
        repeat (2) drive_cycle();
    endtask

    task automatic start_test(output int s);
        ack_cyc.delete();
        ack_port.delete();
        wel_cnt = 0;
        age0 = 0;
        age1 = 0;
        s = cyc;
    endtask

    initial begin
        int s;
        logic [9:0] seq;
        reset_n = 1; sram_din = '0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        model_reset();
        #1 reset_n = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_doe", sram_doe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_acks", {p0_ack, p1_ack}, 0);
        repeat (3) drive_cycle();
        reset_n = 1;
        smem[21'h1ABCD] = 8'h5A;
        mmem[21'h1ABCD] = 8'h5A;

        // Port-0 read
        start_test(s);
        q0.push_back(mk(1'b0, 21'h1ABCD, 8'h00));
        run_until_idle(40);
        chk("t1_ack_count", ack_cyc.size(), 1);
        chk("t1_latency", ack_at(0) - (s + 2), 4);
        chk("t1_port", port_at(0), 0);
        chk("t1_rdata", p0_rdata, 8'h5A);
        chk("t1_we_n_low_cycles", wel_cnt, 0);

        // Port-1 write
        start_test(s);
        q1.push_back(mk(1'b1, 21'h00010, 8'hC3));
        run_until_idle(40);
        chk("t2_latency", ack_at(0) - (s + 2), 4);
        chk("t2_port", port_at(0), 1);
        chk("t2_we_n_low_cycles", wel_cnt, 2);
        chk("t2_mem", sread(21'h00010), 8'hC3);

        // Simultaneous requests
        start_test(s);
        q0.push_back(mk(1'b0, 21'h00010, 8'h00));
        q1.push_back(mk(1'b1, 21'h00020, 8'h3C));
        run_until_idle(60);
        chk("t3_first", port_at(0), 0);
        chk("t3_second", port_at(1), 1);
        chk("t3_spacing", ack_at(1) - ack_at(0), 5);
        chk("t3_p0_rdata", p0_rdata, 8'hC3);

        // Starvation guard
        start_test(s);
        for (int i = 0; i < 8; i++) q0.push_back(mk(1'b0, AW'(21'h00100 + i), 8'h00));
        for (int i = 0; i < 2; i++) q1.push_back(mk(1'b1, AW'(21'h00200 + i), 8'(8'h90 + i)));
        run_until_idle(200);
        seq = '0;
        for (int i = 0; i < 10; i++) seq = {seq[8:0], (port_at(i) == 1)};
        chk("t4_grant_order", seq, 10'b0000100001);
        chk("t4_span", ack_at(9) - ack_at(0), 45);

        // Reset during write
        start_test(s);
        q0.push_back(mk(1'b1, 21'h2A2A2, 8'h77));
        repeat (3) drive_cycle();
        #1;
        chk("t5_we_n_before_reset", sram_we_n, 0);
        reset_n = 0;
        model_reset();
        #1;
        chk("t5_we_n_async", sram_we_n, 1);
        chk("t5_doe_async", sram_doe, 0);
        repeat (2) drive_cycle();
        reset_n = 1;
        run_until_idle(40);
        chk("t5_ack_count", ack_cyc.size(), 1);
        chk("t5_mem", sread(21'h2A2A2), 8'h77);

        // Back-to-back
        start_test(s);
        for (int i = 0; i < 3; i++) q0.push_back(mk(1'b0, AW'(21'h00100 + i), 8'h00));
        run_until_idle(60);
        chk("t6_gap1", ack_at(1) - ack_at(0), 5);
        chk("t6_gap2", ack_at(2) - ack_at(1), 5);

        // Random traffic
        start_test(s);
        rnd_en = 1'b1;
        repeat (3000) drive_cycle();
        rnd_en = 1'b0;
        run_until_idle(200);
        chk("rand_acks_seen", ack_cyc.size() > 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for the external 8-bit asynchronous SRAM (21-bit address space, 2 MB). Port 0 is the core (CPU/ULA) side. Port 1 is a secondary bus master (DMA / framescaler / loader). The block serialises their requests and generates address-setup, strobe and hold phases on the SRAM pins. It sits between the machine core and the top-level `sram_addr` / `sram_data` / `sram_we_n` pads. The tri-state pad buffer stays at top level, driven from `sram_dout` / `sram_doe`.

## Interface
Parameters:
- `AW`, 21 — address width.
- `RD_WAIT`, 2 — ACCESS cycles for a read (≥1); data sampled on the last one.
- `WR_WAIT`, 2 — ACCESS cycles for a write (≥1); `sram_we_n` low for exactly this many cycles.
- `STARVE_LIMIT`, 4 — consecutive port-0 grants allowed while port 1 is pending (≥1).

Ports:
- `sysclk` in 1 — single clock. All logic is on the rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `p0_req`, `p1_req` in 1 — access request; held high until the corresponding ack.
- `p0_we`, `p1_we` in 1 — 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in AW — byte address.
- `p0_wdata`, `p1_wdata` in 8 — write data.
- `p0_ack`, `p1_ack` out 1 — one-cycle completion pulse.
- `p0_rdata`, `p1_rdata` out 8 — read data. Valid from the ack cycle and held until that port's next read completes.
- `sram_addr` out AW — SRAM address.
- `sram_dout` out 8 — data to the pad.
- `sram_doe` out 1 — pad output enable (1 = FPGA drives the data bus).
- `sram_din` in 8 — data from the pad.
- `sram_we_n` out 1 — SRAM write strobe, active low.
- `busy` out 1 — high in any state other than IDLE.
- `owner` out 1 — port currently or last granted.

## Operation
FSM states: IDLE → SETUP → ACCESS → HOLD → IDLE.

IDLE:
- Samples `p0_req` and `p1_req`.
- If either is high, arbitrates, latches the winner's `we`/`addr`/`wdata` into internal registers, and goes to SETUP.
- The latched values drive the SRAM pins; requester inputs are ignored until the next IDLE.

Arbitration:
- Port 0 wins by default.
- Port 1 wins if only port 1 is requesting, or if both are requesting and `starve_cnt == STARVE_LIMIT`.
- `starve_cnt` increments on each port-0 grant made while `p1_req` is high, saturating at STARVE_LIMIT.
- `starve_cnt` clears on any port-1 grant, and in any IDLE cycle where `p1_req` is low.

SETUP (1 cycle):
- `sram_addr` holds the latched address and `sram_we_n` = 1.
- `sram_doe` = latched `we`, and `sram_dout` = latched `wdata`.

ACCESS:
- A wait counter runs from 0 to WAIT−1, where WAIT is RD_WAIT or WR_WAIT according to the latched `we`.
- Write: `sram_we_n` = 0 throughout ACCESS and `sram_doe` = 1.
- Read: `sram_we_n` = 1 and `sram_doe` = 0; on the last ACCESS cycle the winner's `rdata` register loads `sram_din`.

HOLD (1 cycle):
- `sram_we_n` = 1. Address, `sram_dout` and `sram_doe` are unchanged, which gives write data hold.
- The winner's ack is high for this cycle only. Next state is IDLE.

Requester rule:
- At the edge where the requester samples ack = 1, it either drops `req`, or keeps `req` high with new `addr`/`we`/`wdata` to request a new access.
- The following IDLE sees the updated values.
- Changing the request while waiting for ack is not allowed, and the block does not observe such changes.

Data and address paths:
- `sram_addr`, `sram_dout` and `sram_doe` change only on the IDLE→SETUP transition, except that `sram_doe` falls on HOLD→IDLE.
- No read-modify-write. No address arithmetic; addresses pass through unchanged at AW bits.

## Timing
Reset values (all outputs):
- `sram_we_n` = 1, `sram_doe` = 0, `sram_addr` = 0, `sram_dout` = 0.
- Both acks = 0, both `rdata` = 0, `busy` = 0, `owner` = 0, `starve_cnt` = 0, state = IDLE.

Reset mid-operation:
- Asserting `reset_n` forces `sram_we_n` high and `sram_doe` low asynchronously, in the same cycle.
- No ack is issued for the aborted access.
- After release, a still-high request is served from IDLE as new.

Latency and throughput:
- `req` sampled in IDLE at cycle n gives SETUP at n+1, ACCESS at n+2..n+1+WAIT, HOLD with ack at n+2+WAIT, and IDLE at n+3+WAIT.
- Ack latency is WAIT+2 cycles: 4 cycles at the defaults.
- Back-to-back throughput is one access per WAIT+3 cycles.
- A loser's wait is bounded by one in-flight access plus STARVE_LIMIT port-0 accesses.
- If both ports request in the same IDLE cycle, only one is granted. The loser keeps `req` high, with no side effects.
- `owner` updates on the IDLE→SETUP transition and holds through IDLE.

## Test plan
- **Port-0 read.** RD_WAIT=2, `p0_req` with `p0_addr`=0x1ABCD, SRAM model returns 0x5A. Expect `sram_addr`=0x1ABCD from SETUP through HOLD, `p0_ack` 4 cycles after the req sample, `p0_rdata`=0x5A, `sram_we_n` high throughout, `sram_doe` low.
- **Port-1 write.** Address 0x00010, data 0xC3. Expect `sram_doe` high from SETUP through HOLD, `sram_dout`=0xC3, `sram_we_n` low for exactly 2 cycles (ACCESS only), `p1_ack` in HOLD, model memory holding 0xC3 at 0x00010.
- **Simultaneous requests.** Both ports request in the same cycle. Expect port 0 granted first, port 1 in the next IDLE, each ack exactly one cycle, no overlap.
- **Starvation guard.** `p0_req` held high continuously with new addresses, `p1_req` high. Expect the grant order p0, p0, p0, p0, p1, with `starve_cnt` cleared after the port-1 grant.
- **Reset during write.** `reset_n` pulled low in the first write ACCESS cycle. Expect `sram_we_n`=1 and `sram_doe`=0 immediately, no ack. After release the held request completes normally.
- **Back-to-back.** Port 0 keeps `req` high with 3 consecutive addresses. Expect acks spaced exactly WAIT+3 = 5 cycles apart at defaults.
